// File: rtl/wave_meter.sv
// Period and min/max amplitude meter for an 8-bit waveform stream.
// Rising mid-scale crossings with hysteresis delimit each measured period.
module wave_meter #(
    parameter int         CNT_W = 16,
    parameter logic [7:0] MID   = 8'd128,
    parameter logic [7:0] HYST  = 8'd8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sample_valid,
    input  logic [7:0]       sample,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       vmax,
    output logic [7:0]       vmin,
    output logic             meas_valid,
    output logic             overflow,
    output logic             locked
);

    localparam logic [7:0]       LOW_TH  = MID - HYST;
    localparam logic [7:0]       HIGH_TH = MID + HYST;
    localparam logic [CNT_W-1:0] CNT_SAT = {{(CNT_W-1){1'b1}}, 1'b0};

    // REPORT follows a measured crossing and otherwise behaves like SEEK_LOW.
    typedef enum logic [1:0] {SEEK_LOW, SEEK_HIGH, REPORT} state_t;

    state_t           state, state_nxt;
    logic             started;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf;
    logic [7:0]       rmin, rmax;
    logic [7:0]       cur_min, cur_max;
    logic             accept, crossing, report;

    assign accept  = en && sample_valid;
    assign cnt_inc = cnt + CNT_W'(1);
    assign cur_max = (sample > rmax) ? sample : rmax;
    assign cur_min = (sample < rmin) ? sample : rmin;
    assign report  = crossing && started;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        crossing  = 1'b0;
        if (accept) begin
            case (state)
                SEEK_LOW, REPORT: begin
                    if (sample <= LOW_TH) state_nxt = SEEK_HIGH;
                end
                SEEK_HIGH: begin
                    if (sample >= HIGH_TH) begin
                        crossing  = 1'b1;
                        state_nxt = started ? REPORT : SEEK_LOW;
                    end
                end
                default: state_nxt = SEEK_LOW;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEEK_LOW;
            started    <= 1'b0;
            cnt        <= '0;
            ovf        <= 1'b0;
            rmin       <= 8'hFF;
            rmax       <= 8'h00;
            period     <= '0;
            vmax       <= 8'h00;
            vmin       <= 8'hFF;
            meas_valid <= 1'b0;
            overflow   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state      <= state_nxt;
            meas_valid <= report;
            if (crossing) begin
                // The crossing sample closes the old period and seeds the new one.
                started <= 1'b1;
                cnt     <= '0;
                ovf     <= 1'b0;
                rmin    <= sample;
                rmax    <= sample;
                if (started) begin
                    period   <= ovf ? '1 : cnt_inc;
                    overflow <= ovf;
                    vmax     <= cur_max;
                    vmin     <= cur_min;
                    locked   <= 1'b1;
                end
            end else if (accept && started) begin
                if (cnt != CNT_SAT) cnt <= cnt_inc;
                if (cnt_inc == CNT_SAT) ovf <= 1'b1;
                rmin <= cur_min;
                rmax <= cur_max;
            end
        end
    end

endmodule

// File: doc/wave_meter.md
# wave_meter

Measurement block for the function generator's 8-bit waveform output: samples the `wave` stream, detects rising mid-scale crossings with hysteresis, and reports period in samples plus min/max amplitude per period. Provides the receive-side check for the waveform generator so a bench or on-board display can confirm frequency selection, phase and enable behaviour without inspecting waveforms by hand. Sits downstream of the generator, in the same clock domain.

## Interface
- `CNT_W`, 16, width of period counter and `period` output
- `MID`, 128, mid-scale crossing level
- `HYST`, 8, hysteresis half-width; low threshold `MID-HYST`, high threshold `MID+HYST`
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `en`  in  1  measurement enable; low freezes all state
- `sample_valid`  in  1  `sample` valid this cycle
- `sample`  in  8  unsigned waveform sample (generator `wave`)
- `period`  out  CNT_W  valid samples between last two rising crossings
- `vmax`  out  8  max sample over last measured period
- `vmin`  out  8  min sample over last measured period
- `meas_valid`  out  1  one-cycle pulse when `period/vmax/vmin` update
- `overflow`  out  1  period counter saturated since last crossing
- `locked`  out  1  at least one full period measured since reset

Clock is `clk`; reset is `rst`, synchronous, active-high.

## Operation
- One sample is accepted only when `en && sample_valid`; any other cycle: no state, counter or register changes, `meas_valid` = 0.
- FSM, 3 states:
  - SEEK_LOW (reset state): accepted `sample <= MID-HYST` -> SEEK_HIGH.
  - SEEK_HIGH: accepted `sample >= MID+HYST` = rising crossing. If `started`=0: set `started`, clear counter, load running min/max with `sample`, stay in SEEK_LOW path (-> SEEK_LOW). If `started`=1: -> REPORT behaviour in same cycle, then SEEK_LOW.
  - Samples between thresholds never change state (hysteresis).
- Counter `cnt`: +1 on every accepted non-crossing sample once `started`; saturates at `2^CNT_W-2`; reaching saturation sets internal `ovf`.
- Running `rmin/rmax`: update with each accepted sample once `started`.
- On crossing with `started`=1 (registered, visible next cycle):
  - `period <= ovf ? all-ones : cnt+1`; `overflow <= ovf`.
  - `vmax <= max(rmax, sample)`, `vmin <= min(rmin, sample)`.
  - `meas_valid` = 1 for one cycle; `locked <= 1`.
  - `cnt <= 0`, `ovf <= 0`, `rmin <= rmax <= sample`.
- A sample that is both the last of one period and the first of the next (the crossing sample) counts toward the period it closes and seeds min/max of the next.
- Constant signal, or signal never leaving the hysteresis band: no crossing; `cnt` saturates; outputs hold last values.

## Timing
- Reset values: `period`=0, `vmax`=0, `vmin`=8'hFF, `meas_valid`=0, `overflow`=0, `locked`=0; FSM SEEK_LOW, `started`=0, `cnt`=0.
- Latency: outputs and `meas_valid` assert the cycle after the crossing sample is accepted.
- `meas_valid` never asserts on consecutive cycles (crossing needs a SEEK_LOW pass first).
- `en` low mid-period: counting pauses; resumes exactly where it left off; paused cycles not counted.
- `rst` mid-period: all state returns to reset values next edge; first crossing after reset only arms (`locked` stays 0 until second crossing).
- Width rule: `cnt+1` computed in CNT_W bits; never wraps due to saturation at `2^CNT_W-2`.

## Test plan
- Square wave, 10 samples of 0 then 10 of 255, `sample_valid`=1 every cycle -> after second crossing `period`=20, `vmax`=255, `vmin`=0, `meas_valid` pulses every 20 cycles, `locked`=1.
- Sawtooth 0..255 step 1, `sample_valid` every other cycle -> `period`=256, `vmin`=0, `vmax`=255; pulse spacing 512 clocks.
- Square 100/156 with ±6 noise inside band (122..134 on alternate samples mid-half) -> no extra crossings; `period` unchanged from clean-signal value.
- Constant 200 after one crossing, CNT_W=8 -> no `meas_valid`; next crossing reports `period`=8'hFF, `overflow`=1; following clean period reports `overflow`=0.
- `en` low for 37 cycles inside a 20-sample square period -> reported `period` still 20.
- `rst` pulsed mid-period after lock -> all outputs at reset values; first new crossing gives no pulse; second gives correct `period`.
